// File: rtl/ttq_pkg.sv
// Shared constants, FSM state encoding and count helper for the ttq_reader block.
package ttq_pkg;

  localparam int TTQ_DATA_W_DEF = 64;
  localparam int TTQ_WINDOW_DEF = 4;
  localparam int TTQ_COUNT_W    = 8;

  typedef enum logic [1:0] {
    TTQ_IDLE = 2'd0,
    TTQ_POP  = 2'd1,
    TTQ_ACK  = 2'd2
  } ttq_state_e;

  // Saturating live-entry count step; a simultaneous push and pop cancel out.
  function automatic logic [TTQ_COUNT_W-1:0] ttq_count_step(
    input logic [TTQ_COUNT_W-1:0] cur,
    input logic                   inc,
    input logic                   dec
  );
    logic [TTQ_COUNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != '1)) begin
      nxt = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ttq_accum.sv
// Running sum (and optional live count, TTQ_READER_COUNT_EN) of queue entries.
module ttq_accum
  import ttq_pkg::*;
#(
  parameter int DATA_W = TTQ_DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push_valid,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop_valid,
  input  logic [DATA_W-1:0]      pop_data,
`ifdef TTQ_READER_COUNT_EN
  output logic [TTQ_COUNT_W-1:0] count,
`endif
  output logic [DATA_W-1:0]      sum
);

  logic [DATA_W-1:0] add_term;
  logic [DATA_W-1:0] sub_term;

  assign add_term = push_valid ? push_data : '0;
  assign sub_term = pop_valid  ? pop_data  : '0;

  // Wraps modulo 2^DATA_W; push and pop in the same cycle land as one update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + add_term - sub_term;
    end
  end

`ifdef TTQ_READER_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= ttq_count_step(count, push_valid, pop_valid);
    end
  end
`endif

endmodule

// File: rtl/ttq_reader.sv
// Expires queue heads older than WINDOW cycles; optional count port via TTQ_READER_COUNT_EN.
// States: IDLE wait for expired head | POP hold pop until pop_valid | ACK one-cycle expiry pulse
module ttq_reader
  import ttq_pkg::*;
#(
  parameter int WINDOW = TTQ_WINDOW_DEF,
  parameter int DATA_W = TTQ_DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push_valid,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   head_valid,
  input  logic [63:0]            head_wait,
  output logic                   pop,
  input  logic                   pop_valid,
  input  logic [DATA_W-1:0]      pop_data,
  output logic                   expired_valid,
  output logic [DATA_W-1:0]      expired_data,
  output logic [DATA_W-1:0]      sum,
`ifdef TTQ_READER_COUNT_EN
  output logic [TTQ_COUNT_W-1:0] count,
`endif
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = TTQ_IDLE;
  localparam logic [1:0] S_POP  = TTQ_POP;
  localparam logic [1:0] S_ACK  = TTQ_ACK;

  localparam logic signed [63:0] WIN_S = 64'(WINDOW);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       head_expired;

  // Signed compare so a negative age never counts as expired.
  assign head_expired = head_valid && ($signed(head_wait) >= WIN_S);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (head_expired) state_nx = S_POP;
      S_POP: begin
        if (pop_valid) begin
          state_nx = S_ACK;
        end else if (!head_valid) begin
          state_nx = S_IDLE;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pop           <= 1'b0;
      busy          <= 1'b0;
      expired_valid <= 1'b0;
      expired_data  <= '0;
    end else if (!en) begin
      pop           <= 1'b0;
      expired_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      pop           <= (state_nx == S_POP);
      busy          <= (state_nx != S_IDLE);
      expired_valid <= (state == S_POP) && pop_valid;
      if ((state == S_POP) && pop_valid) begin
        expired_data <= pop_data;
      end
    end
  end

  ttq_accum #(
    .DATA_W(DATA_W)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
`ifdef TTQ_READER_COUNT_EN
    .count      (count),
`endif
    .sum        (sum)
  );

endmodule

// File: tb/tb_ttq_reader.sv
// Directed and randomized checks of ttq_reader against a queue-level reference model.
module tb_ttq_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        push_valid = 1'b0;
  logic [63:0] push_data = '0;
  logic        head_valid = 1'b0;
  logic [63:0] head_wait = '0;
  logic        pop_valid = 1'b0;
  logic [63:0] pop_data = '0;
  logic        pop;
  logic        expired_valid;
  logic [63:0] expired_data;
  logic [63:0] sum;
  logic        busy;
`ifdef TTQ_READER_COUNT_EN
  logic [7:0]  count;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] d;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_sum;
  logic        exp_pulse;
  logic [63:0] exp_data;
  int          cyc;

  always #5 clk = ~clk;

  ttq_reader #(
    .WINDOW(4),
    .DATA_W(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .head_valid    (head_valid),
    .head_wait     (head_wait),
    .pop           (pop),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .expired_valid (expired_valid),
    .expired_data  (expired_data),
    .sum           (sum),
`ifdef TTQ_READER_COUNT_EN
    .count         (count),
`endif
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; head_valid = 1'b0;
    step();
    rst = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_pop", pop, 1'b0);
    check("rst_expv", expired_valid, 1'b0);
    check("rst_expd", expired_data, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_busy", busy, 1'b0);
`ifdef TTQ_READER_COUNT_EN
    check("rst_count", count, 64'd0);
`endif
    rst = 1'b0;
    en = 1'b1;

    // Head ages to WINDOW, expires, sum drops
    push_valid = 1'b1; push_data = 64'd1;
    step();
    push_valid = 1'b0;
    check("t33_sum1", sum, 64'd1);
    head_valid = 1'b1;
    for (int w = 0; w <= 4; w++) begin
      head_wait = 64'(w);
      step();
      check($sformatf("t33_pop_w%0d", w), pop, (w >= 4) ? 64'd1 : 64'd0);
    end
    check("t33_busy", busy, 1'b1);
    pop_valid = 1'b1; pop_data = 64'd1; head_valid = 1'b0;
    step();
    pop_valid = 1'b0;
    check("t33_expv", expired_valid, 1'b1);
    check("t33_expd", expired_data, 64'd1);
    check("t33_sum0", sum, 64'd0);
    check("t33_popdrop", pop, 1'b0);
    step();
    check("t33_expv_end", expired_valid, 1'b0);
    check("t33_idle", busy, 1'b0);

    // Sum accumulation and same-cycle push/pop
    push_valid = 1'b1; push_data = 64'd2;
    step();
    push_data = 64'd3;
    step();
    push_valid = 1'b0;
    check("t34_sum5", sum, 64'd5);
    push_valid = 1'b1; push_data = 64'd4; pop_valid = 1'b1; pop_data = 64'd2;
    step();
    push_valid = 1'b0; pop_valid = 1'b0;
    check("t34_sum7", sum, 64'd7);
    check("t34_noexp", expired_valid, 1'b0);

    // Abort when head disappears during POP
    head_valid = 1'b1; head_wait = 64'd10;
    step();
    check("t35_pop", pop, 1'b1);
    head_valid = 1'b0;
    step();
    check("t35_pop0", pop, 1'b0);
    check("t35_busy0", busy, 1'b0);
    check("t35_noexp", expired_valid, 1'b0);
    check("t35_sum", sum, 64'd7);

    // Disabled with an expired head
    en = 1'b0; head_valid = 1'b1; head_wait = 64'd10;
    push_valid = 1'b1; push_data = 64'd5;
    step();
    check("t36_pop_off", pop, 1'b0);
    check("t36_busy_off", busy, 1'b0);
    check("t36_sum_hold", sum, 64'd7);
    step();
    check("t36_pop_off2", pop, 1'b0);
    check("t36_sum_hold2", sum, 64'd7);
    push_valid = 1'b0; en = 1'b1;
    step();
    check("t36_pop_on", pop, 1'b1);
    pop_valid = 1'b1; pop_data = 64'd3; head_valid = 1'b0;
    step();
    pop_valid = 1'b0;
    check("t36_expv", expired_valid, 1'b1);
    check("t36_expd", expired_data, 64'd3);
    check("t36_sum4", sum, 64'd4);

    // Negative age is never expired
    head_valid = 1'b1; head_wait = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    step();
    check("neg_age_pop", pop, 1'b0);

    // Async reset while pop is high
    head_wait = 64'd10;
    step();
    check("t37_pop", pop, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t37_pop_async", pop, 1'b0);
    check("t37_sum_async", sum, 64'd0);
    check("t37_busy_async", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    head_valid = 1'b0; pop_valid = 1'b1; pop_data = 64'd9;
    step();
    pop_valid = 1'b0;
    check("t37_nopulse", expired_valid, 1'b0);
    check("t37_sum_ext", sum, 64'hFFFF_FFFF_FFFF_FFF7);
    check("t37_busy", busy, 1'b0);

`ifdef TTQ_READER_COUNT_EN
    // Count saturation at zero
    do_reset();
    push_data = 64'd1;
    for (int k = 1; k <= 3; k++) begin
      push_valid = 1'b1;
      step();
      push_valid = 1'b0;
      check($sformatf("t38_cnt_push%0d", k), count, 64'(k));
    end
    pop_data = 64'd1;
    for (int k = 1; k <= 4; k++) begin
      pop_valid = 1'b1;
      step();
      pop_valid = 1'b0;
      check($sformatf("t38_cnt_pop%0d", k), count, (k >= 3) ? 64'd0 : 64'(3 - k));
    end
    check("t38_sum_neg1", sum, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // Sum wraps without saturation
    do_reset();
    push_valid = 1'b1; push_data = 64'h7FFF_FFFF_FFFF_FFFF;
    step();
    push_data = 64'd1;
    step();
    push_valid = 1'b0;
    check("t38_wrap", sum, 64'h8000_0000_0000_0000);

    // Randomized traffic against a queue model
    do_reset();
    q.delete();
    m_sum = '0;
    exp_pulse = 1'b0;
    exp_data = '0;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      logic do_push;
      logic do_pop;
      logic resp;
      en = ($urandom_range(0, 15) != 0);
      do_pop = 1'b0;
      resp = 1'b0;
      if (en && (q.size() > 0)) begin
        if (pop && ($urandom_range(0, 1) == 1)) begin
          do_pop = 1'b1;
          resp = 1'b1;
        end else if (!busy && ($urandom_range(0, 15) == 0)) begin
          do_pop = 1'b1;
        end
      end
      do_push = en && (q.size() < 200) && ($urandom_range(0, 2) == 0);
      head_valid = (q.size() > 0);
      head_wait = (q.size() > 0) ? 64'(cyc - q[0].t) : 64'($urandom);
      pop_valid = do_pop;
      pop_data = do_pop ? q[0].d : {$urandom, $urandom};
      push_valid = do_push;
      push_data = {$urandom, $urandom};
      exp_pulse = resp;
      if (resp) exp_data = q[0].d;
      if (do_pop) begin
        m_sum = m_sum - q[0].d;
        void'(q.pop_front());
      end
      if (do_push) begin
        m_sum = m_sum + push_data;
        q.push_back('{d: push_data, t: cyc + 1});
      end
      step();
      cyc++;
      check("rnd_sum", sum, m_sum);
      check("rnd_expv", expired_valid, exp_pulse);
      if (exp_pulse) check("rnd_expd", expired_data, exp_data);
`ifdef TTQ_READER_COUNT_EN
      check("rnd_count", count, 64'(q.size()));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttq_reader.md
TTQ_READER -- requirements
Module: ttq_reader

Interface
REQ-001 SHALL have parameter WINDOW, default 4: minimum head age, in clock cycles, before an entry is expired.
REQ-002 SHALL have parameter DATA_W, default 64: signed data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  in  1  clock enable.
REQ-006 SHALL have port push_valid  in  1  queue accepted a push this cycle.
REQ-007 SHALL have port push_data  in  DATA_W  signed value pushed.
REQ-008 SHALL have port head_valid  in  1  queue non-empty.
REQ-009 SHALL have port head_wait  in  64  signed age of the oldest entry, in cycles.
REQ-010 SHALL have port pop  out  1  pop request to the queue.
REQ-011 SHALL have port pop_valid  in  1  queue delivered the oldest entry this cycle.
REQ-012 SHALL have port pop_data  in  DATA_W  signed popped value.
REQ-013 SHALL have port expired_valid  out  1  one-cycle pulse per expired entry.
REQ-014 SHALL have port expired_data  out  DATA_W  value of the expired entry.
REQ-015 SHALL have port sum  out  DATA_W  signed running sum of live entries.
REQ-016 SHALL have port busy  out  1  FSM not IDLE.

Function
REQ-017 SHALL implement FSM {IDLE, POP, ACK}, with all outputs registered.
REQ-018 IDLE->POP SHALL occur when en && head_valid && head_wait >= WINDOW; pop SHALL assert the following cycle.
REQ-019 In POP, pop SHALL stay 1 until pop_valid is seen, then the FSM SHALL go to ACK and pop SHALL drop the next cycle.
REQ-020 ACK SHALL last one cycle with expired_valid=1 and expired_data=captured pop_data, then return to IDLE; throughput SHALL be at most one expiry per 3 cycles.
REQ-021 If head_valid falls while in POP without pop_valid, the FSM SHALL abort to IDLE with no expiry pulse and no sum change.
REQ-022 A pop_valid arriving in IDLE or ACK SHALL be ignored for FSM purposes but still subtracted from sum (external pop).
REQ-023 On push_valid, sum SHALL increase by push_data; on pop_valid, sum SHALL decrease by pop_data; if both occur the same cycle, sum SHALL update by push_data - pop_data in one step.
REQ-024 Sum arithmetic SHALL be two's complement modulo 2^DATA_W, with no saturation.
REQ-025 When en=0, the FSM, sum, and counters SHALL hold; pop SHALL be forced to 0; expired_valid SHALL be 0.
REQ-026 head_wait < 0 SHALL be treated as not expired.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, pop=0, expired_valid=0, expired_data=0, sum=0, busy=0, count=0.
REQ-028 Reset asserted mid-POP SHALL drop pop asynchronously; the in-flight pop_valid SHALL be ignored.

Configuration
REQ-029 With TTQ_READER_COUNT_EN defined, the module SHALL add output count (8 bits): live entries, +1 per push, -1 per pop, saturating at 0 and 255.
REQ-030 Without TTQ_READER_COUNT_EN, the count port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package ttq_pkg SHALL hold the DATA_W default, the WINDOW default, the FSM state enum, and the count width constant.
REQ-032 The block SHALL include one sub-module, ttq_accum (the sum/count accumulator); the FSM SHALL live in ttq_reader.

Verification
REQ-033 Push 1 at t0, head_wait ramps 0..4 -> pop asserts 1 cycle after head_wait=4; on pop_valid with data 1 -> expired_valid pulse, expired_data=1, sum 1->0.
REQ-034 Push 2 then push 3, sum=5; same-cycle push 4 and pop_valid with data 2 -> sum=7 in one cycle.
REQ-035 In POP, drop head_valid before pop_valid -> FSM back to IDLE, no expired pulse, sum unchanged.
REQ-036 Hold en=0 with an expired head -> pop stays 0 and sum holds; raise en -> pop asserts the next cycle.
REQ-037 Assert rst while pop=1 -> pop=0, sum=0, busy=0 immediately; a later pop_valid gives no pulse.
REQ-038 With TTQ_READER_COUNT_EN: 3 pushes then 4 pop_valid -> count 3, then 0 (saturates, no wrap); sum=0x7FFF_FFFF_FFFF_FFFF plus push 1 -> 0x8000_0000_0000_0000.
